// File: rtl/matrix_scroll_ctrl.sv
// rtl/matrix_scroll_ctrl.sv - hex message sequencer driving 5x7 matrix columns
module matrix_scroll_ctrl #(
    parameter int MAX_CHARS = 16,
    parameter int ADDR_W    = 4,
    parameter int GAP_COLS  = 1,
    parameter int PAD_COLS  = 5
) (
    input  logic              clk_6hz,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    output logic              wr_ready,
    output logic [6:0]        prox_col,
    output logic              busy,
    output logic              wrap_pulse
);

    // Column index of the last gap column; a character occupies 5 + GAP_COLS steps.
    localparam int STEP_LAST = 4 + GAP_COLS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] char_idx_q, char_idx_d;
    logic [2:0]        col_idx_q, col_idx_d;
    logic [3:0]        pad_cnt_q, pad_cnt_d;
    logic              in_pad_q, in_pad_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [6:0]        prox_q, prox_d;
    logic              wrap_q, wrap_d;
    logic [3:0]        msg_buf_q [MAX_CHARS];

    logic              wr_ok;
    logic [3:0]        cur_code;
    logic              last_char;

    // Glyph ROM: columns packed leftmost first, bit 6 of each column is the top row.
    function automatic logic [6:0] glyph_col(input logic [3:0] code, input logic [2:0] col);
        logic [34:0] g;
        logic [6:0]  c;
        case (code)
            4'h0: g = {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E};
            4'h1: g = {7'h00, 7'h21, 7'h7F, 7'h01, 7'h00};
            4'h2: g = {7'h21, 7'h43, 7'h45, 7'h49, 7'h31};
            4'h3: g = {7'h42, 7'h41, 7'h51, 7'h69, 7'h46};
            4'h4: g = {7'h0C, 7'h14, 7'h24, 7'h7F, 7'h04};
            4'h5: g = {7'h72, 7'h51, 7'h51, 7'h51, 7'h4E};
            4'h6: g = {7'h1E, 7'h29, 7'h49, 7'h49, 7'h06};
            4'h7: g = {7'h40, 7'h47, 7'h48, 7'h50, 7'h60};
            4'h8: g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'h9: g = {7'h30, 7'h49, 7'h49, 7'h4A, 7'h3C};
            4'hA: g = {7'h3F, 7'h44, 7'h44, 7'h44, 7'h3F};
            4'hB: g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
            4'hC: g = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            4'hD: g = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            4'hE: g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            default: g = {7'h7F, 7'h48, 7'h48, 7'h48, 7'h40};
        endcase
        case (col)
            3'd0:    c = g[34:28];
            3'd1:    c = g[27:21];
            3'd2:    c = g[20:14];
            3'd3:    c = g[13:7];
            3'd4:    c = g[6:0];
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    assign wr_ready   = (state_q != S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign prox_col   = prox_q;
    assign wrap_pulse = wrap_q;

    assign wr_ok     = wr_en && wr_ready && ({1'b0, wr_addr} < (ADDR_W+1)'(MAX_CHARS));
    assign cur_code  = msg_buf_q[char_idx_q];
    assign last_char = ({1'b0, char_idx_q} == (len_q - 1'b1));

    // Next-state and scroll-step logic; counters only move on RUN edges without stop.
    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        col_idx_d  = col_idx_q;
        pad_cnt_d  = pad_cnt_q;
        in_pad_d   = in_pad_q;
        len_d      = len_q;
        prox_d     = 7'h00;
        wrap_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (msg_len != '0)) begin
                    state_d    = S_RUN;
                    len_d      = (msg_len > (ADDR_W+1)'(MAX_CHARS)) ? (ADDR_W+1)'(MAX_CHARS) : msg_len;
                    char_idx_d = '0;
                    col_idx_d  = '0;
                    pad_cnt_d  = '0;
                    in_pad_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (in_pad_q) begin
                    if (pad_cnt_q == 4'(PAD_COLS - 1)) begin
                        wrap_d     = 1'b1;
                        pad_cnt_d  = '0;
                        in_pad_d   = 1'b0;
                        char_idx_d = '0;
                        col_idx_d  = '0;
                    end else begin
                        pad_cnt_d = pad_cnt_q + 4'd1;
                    end
                end else begin
                    if (col_idx_q < 3'd5) begin
                        prox_d = glyph_col(cur_code, col_idx_q);
                    end
                    if (col_idx_q == 3'(STEP_LAST)) begin
                        col_idx_d = '0;
                        if (last_char) begin
                            in_pad_d = 1'b1;
                        end else begin
                            char_idx_d = char_idx_q + 1'b1;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 3'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d    = S_IDLE;
                    char_idx_d = '0;
                    col_idx_d  = '0;
                    pad_cnt_d  = '0;
                    in_pad_d   = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_6hz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            char_idx_q <= '0;
            col_idx_q  <= '0;
            pad_cnt_q  <= '0;
            in_pad_q   <= 1'b0;
            len_q      <= '0;
            prox_q     <= 7'h00;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            col_idx_q  <= col_idx_d;
            pad_cnt_q  <= pad_cnt_d;
            in_pad_q   <= in_pad_d;
            len_q      <= len_d;
            prox_q     <= prox_d;
            wrap_q     <= wrap_d;
        end
    end

    // Message buffer; writes are locked out while scrolling.
    always_ff @(posedge clk_6hz) begin
        if (rst) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                msg_buf_q[i] <= 4'h0;
            end
        end else if (wr_ok) begin
            msg_buf_q[wr_addr] <= wr_data;
        end
    end

endmodule
